// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM target with clear sweep, byte/half/word stores, 2-cycle loads
// Optional: MEM_RESPONDER_ALIGN_FAULT_EN rejects misaligned or reserved-width stores with a fault pulse.
module mem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] addr,
    input  logic            wenable,
    input  logic [1:0]      wwidth,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            rdata_valid,
    output logic            fault,
    output logic            init_done
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_req_ready;
    logic            r_init_done;
    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_data;
    logic            r_rdata_valid;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_load;
    logic            w_store;
    logic            w_misalign;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdat;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_idx;
    logic [3:0]      w_mem_be;
    logic [XLEN-1:0] w_mem_data;
    logic            w_unused;

    assign w_unused = &{1'b0, addr[XLEN-1:AW+2]};
    assign w_accept = req_valid && r_req_ready;
    assign w_idx    = addr[AW+1:2];
    assign w_load   = w_accept && !wenable;

    // Sub-word stores replicate the data across the word so only the byte enables pick lanes.
    always_comb begin
        w_be   = 4'b1111;
        w_wdat = wdata;
        case (wwidth)
            2'd0: begin
                w_be   = 4'b0001 << addr[1:0];
                w_wdat = {4{wdata[7:0]}};
            end
            2'd1: begin
                w_be   = addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wdat = wdata;
            end
        endcase
    end

`ifdef MEM_RESPONDER_ALIGN_FAULT_EN
    assign w_misalign = ((wwidth == 2'd1) && addr[0]) ||
                        ((wwidth == 2'd2) && (addr[1:0] != 2'd0)) ||
                        (wwidth == 2'd3);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_store    = w_accept && wenable && !w_misalign;
    assign w_mem_we   = !rst && ((r_state == S_CLEAR) || w_store);
    assign w_mem_idx  = (r_state == S_CLEAR) ? r_clr_idx : w_idx;
    assign w_mem_be   = (r_state == S_CLEAR) ? 4'b1111 : w_be;
    assign w_mem_data = (r_state == S_CLEAR) ? '0 : w_wdat;

    // RAM array and load stage 1 carry no reset so they can map to block memory.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_mem_data[8*i +: 8];
                end
            end
        end
        if (w_load) begin
            r_s1_data <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_CLEAR;
            r_clr_idx     <= '0;
            r_req_ready   <= 1'b0;
            r_init_done   <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_s1_valid    <= w_load;
            r_rdata_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rdata <= r_s1_data;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state     <= S_READY;
                        r_req_ready <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

`ifdef MEM_RESPONDER_ALIGN_FAULT_EN
    logic r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_accept && wenable && w_misalign;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign req_ready   = r_req_ready;
    assign init_done   = r_init_done;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder against a byte-array reference model
module tb_mem_responder;
    localparam int DEPTH = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic        wenable = 1'b0;
    logic [1:0]  wwidth = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic        init_done;

    mem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wenable(wenable), .wwidth(wwidth), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       rq[$];
    int         fq[$];
    logic [7:0] model [NBYTES];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every rdata_valid / fault pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rdata_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rdata_latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (fault) begin
                if (fq.size() == 0) begin
                    chk("unexpected_fault", 32'd1, 32'd0);
                end else begin
                    int c;
                    c = fq.pop_front();
                    chk("fault_cycle", 32'(cyc), 32'(c));
                end
            end
        end
    end

    function automatic bit exp_fault(input logic [1:0] w, input logic [31:0] a);
`ifdef MEM_RESPONDER_ALIGN_FAULT_EN
        return (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0) || (w == 2'd3);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;
    endtask

    // One request per call; the model is updated and expectations queued at issue time.
    task automatic do_req(input bit we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        int base;
        @(negedge clk);
        req_valid = 1'b1;
        wenable   = we;
        wwidth    = w;
        addr      = a;
        wdata     = d;
        base      = int'(a % NBYTES);
        if (we) begin
            if (exp_fault(w, a)) begin
                fq.push_back(cyc + 1);
            end else if (w == 2'd0) begin
                model[base] = d[7:0];
            end else if (w == 2'd1) begin
                base = base - (base % 2);
                model[base]     = d[7:0];
                model[base + 1] = d[15:8];
            end else begin
                base = base - (base % 4);
                for (int k = 0; k < 4; k++) model[base + k] = d[8*k +: 8];
            end
        end else begin
            exp_t e;
            base   = base - (base % 4);
            e.data = {model[base + 3], model[base + 2], model[base + 1], model[base]};
            e.cyc  = cyc + 2;
            rq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    endtask

    task automatic release_and_sweep(input string tag);
        int cnt;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (!req_ready && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_sweep_cycles"}, 32'(cnt), 32'(DEPTH));
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        model_clear();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() != 0 || fq.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_rq_empty", 32'(rq.size()), 32'd0);
        chk("drain_fq_empty", 32'(fq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        release_and_sweep("sweep1");

        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 2'd0, 32'(i * 4), 32'd0);
        idle(1);

        do_req(1'b1, 2'd2, 32'h40, 32'h11223344);
        do_req(1'b1, 2'd0, 32'h41, 32'h000000AA);
        do_req(1'b1, 2'd1, 32'h42, 32'h0000BEEF);
        do_req(1'b0, 2'd2, 32'h40, 32'h0);
        idle(1);

        do_req(1'b1, 2'd2, 32'h0, 32'd1);
        do_req(1'b1, 2'd2, 32'h4, 32'd2);
        do_req(1'b1, 2'd2, 32'h8, 32'd3);
        do_req(1'b0, 2'd2, 32'h0, 32'h0);
        do_req(1'b0, 2'd2, 32'h4, 32'h0);
        do_req(1'b0, 2'd2, 32'h8, 32'h0);
        idle(1);

        do_req(1'b1, 2'd2, 32'h10, 32'h5);
        do_req(1'b0, 2'd2, 32'h10, 32'h0);
        do_req(1'b1, 2'd2, 32'h50, 32'hCAFE0001);
        do_req(1'b0, 2'd2, 32'h10, 32'h0);
        do_req(1'b1, 2'd2, 32'h10, 32'h77777777);
        idle(1);

        do_req(1'b1, 2'd2, 32'h22, 32'hFFFFFFFF);
        do_req(1'b0, 2'd2, 32'h20, 32'h0);
        do_req(1'b1, 2'd3, 32'h24, 32'h12345678);
        do_req(1'b1, 2'd1, 32'h29, 32'h0000ABCD);
        do_req(1'b0, 2'd2, 32'h24, 32'h0);
        do_req(1'b0, 2'd2, 32'h28, 32'h0);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        idle(1);
        drain();

        do_req(1'b0, 2'd2, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        rq.delete();
        #1;
        check_reset_outputs("midload");
        repeat (3) @(posedge clk);
        release_and_sweep("sweep2");
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 2'd2, 32'(i * 4), 32'd0);
        idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
